// File: rtl/tone_recorder.sv
// tone_recorder: measures a square-wave input and emits (half-period, duration) frames
// through a one-entry valid/ready register; (0,0) terminates a recording.
`default_nettype none

module tone_recorder #(
  parameter int          SAMPLE_DIV      = 128,
  parameter int          SEQ_DIV         = 48828,
  parameter logic [15:0] SILENCE_SAMPLES = 16'd4096,
  parameter logic [15:0] TOLERANCE       = 16'd2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        STOP,
  input  logic        AUDIO_IN,
  output logic        FRAME_VALID,
  input  logic        FRAME_READY,
  output logic [15:0] FRAME_PERIOD,
  output logic [9:0]  FRAME_DUR,
  output logic        OVERFLOW,
  output logic        BUSY
);

  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int QW = (SEQ_DIV > 1) ? $clog2(SEQ_DIV) : 1;
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
  localparam logic [QW-1:0] SEQ_LAST    = QW'(SEQ_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SILENCE = 2'd1,
    ACQUIRE = 2'd2,
    TONE    = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          audio_s1, audio_s2, audio_d;
  logic [SW-1:0] samp_cnt;
  logic [15:0]   half_cnt, half_meas, pitch_diff;
  logic [QW-1:0] clk_cnt;
  logic [10:0]   tick_cnt;
  logic [15:0]   period, period_nxt;
  logic          enable_d, term_pend;
  logic          sample_tick, edge_det, sil_hit, off_pitch;
  logic          close, open, wr, slot_free;
  logic [9:0]    dur_wr;

  assign sample_tick = (samp_cnt == SAMPLE_LAST);
  assign edge_det    = sample_tick && (audio_s2 != audio_d);
  // half_meas includes the current tick, so it is the half-period ending at this edge
  assign half_meas   = (half_cnt >= SILENCE_SAMPLES) ? SILENCE_SAMPLES : half_cnt + 16'd1;
  assign sil_hit     = sample_tick && !edge_det && (half_cnt == SILENCE_SAMPLES - 16'd1);
  assign pitch_diff  = (half_meas > period) ? half_meas - period : period - half_meas;
  assign off_pitch   = pitch_diff > TOLERANCE;

  assign dur_wr    = 10'(tick_cnt - 11'd1);
  assign wr        = close && (tick_cnt != 11'd0) && !((period == 16'd0) && (tick_cnt == 11'd1));
  assign slot_free = !FRAME_VALID || FRAME_READY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      audio_s1 <= 1'b0;
      audio_s2 <= 1'b0;
      audio_d  <= 1'b0;
      samp_cnt <= '0;
      half_cnt <= 16'd0;
    end else begin
      audio_s1 <= AUDIO_IN;
      audio_s2 <= audio_s1;
      samp_cnt <= sample_tick ? '0 : samp_cnt + SW'(1);
      if (sample_tick) begin
        audio_d  <= audio_s2;
        half_cnt <= edge_det ? 16'd0 : half_meas;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    period_nxt = period;
    close      = 1'b0;
    open       = 1'b0;
    if (state == IDLE) begin
      if (ENABLE && !enable_d) begin
        state_nxt  = SILENCE;
        period_nxt = 16'd0;
        open       = 1'b1;
      end
    end else if (STOP || !ENABLE) begin
      close     = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        SILENCE: if (edge_det) begin
          close = 1'b1; open = 1'b1; period_nxt = 16'd0; state_nxt = ACQUIRE;
        end
        ACQUIRE: if (edge_det) begin
          period_nxt = half_meas; state_nxt = TONE;
        end else if (sil_hit) begin
          period_nxt = 16'd0; state_nxt = SILENCE;
        end
        TONE: if (edge_det && off_pitch) begin
          close = 1'b1; open = 1'b1; period_nxt = half_meas;
        end else if (sil_hit) begin
          close = 1'b1; open = 1'b1; period_nxt = 16'd0; state_nxt = SILENCE;
        end
        default: state_nxt = IDLE;
      endcase
      // a frame that fills the 10-bit duration field is split; the tone carries on
      if (!close && (tick_cnt == 11'd1024)) begin
        close = 1'b1;
        open  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      period       <= 16'd0;
      clk_cnt      <= '0;
      tick_cnt     <= 11'd0;
      enable_d     <= 1'b0;
      term_pend    <= 1'b0;
      FRAME_VALID  <= 1'b0;
      FRAME_PERIOD <= 16'd0;
      FRAME_DUR    <= 10'd0;
      OVERFLOW     <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      state    <= state_nxt;
      period   <= period_nxt;
      enable_d <= ENABLE;
      BUSY     <= (state_nxt != IDLE);

      if (open || (state_nxt == IDLE)) begin
        clk_cnt  <= '0;
        tick_cnt <= 11'd0;
      end else if (clk_cnt == SEQ_LAST) begin
        clk_cnt  <= '0;
        tick_cnt <= tick_cnt + 11'd1;
      end else begin
        clk_cnt <= clk_cnt + QW'(1);
      end

      if (FRAME_VALID && FRAME_READY) FRAME_VALID <= 1'b0;
      // a pending terminator owns the free slot; it is never dropped
      if (slot_free && term_pend) begin
        FRAME_VALID  <= 1'b1;
        FRAME_PERIOD <= 16'd0;
        FRAME_DUR    <= 10'd0;
        term_pend    <= 1'b0;
        if (wr) OVERFLOW <= 1'b1;
      end else if (wr) begin
        if (slot_free) begin
          FRAME_VALID  <= 1'b1;
          FRAME_PERIOD <= period;
          FRAME_DUR    <= dur_wr;
        end else begin
          OVERFLOW <= 1'b1;
        end
      end
      if (STOP && (state != IDLE)) term_pend <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tone_recorder.sv
// tb_tone_recorder: table-driven, randomized and directed checks of tone_recorder frames
// against a reference built from edge timestamps.
`default_nettype none

module tb_tone_recorder;
  localparam int SD  = 4;
  localparam int SQ  = 100;
  localparam int SQF = 10;
  localparam int SIL = 64;
  localparam int TOL = 1;

  logic CLK = 1'b0, RESET = 1'b0, ENABLE = 1'b0, STOP = 1'b0, AUDIO_IN = 1'b0, FRAME_READY = 1'b1;
  logic va, vb, ova, ovb, ba, bb;
  logic [15:0] pa, pb;
  logic [9:0]  da, db;

  tone_recorder #(.SAMPLE_DIV(SD), .SEQ_DIV(SQ), .SILENCE_SAMPLES(16'(SIL)), .TOLERANCE(16'(TOL))) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .STOP(STOP), .AUDIO_IN(AUDIO_IN),
    .FRAME_VALID(va), .FRAME_READY(FRAME_READY), .FRAME_PERIOD(pa), .FRAME_DUR(da),
    .OVERFLOW(ova), .BUSY(ba));

  // second instance with a short sequencer tick so the 1024-tick split fits in a short run
  tone_recorder #(.SAMPLE_DIV(SD), .SEQ_DIV(SQF), .SILENCE_SAMPLES(16'(SIL)), .TOLERANCE(16'(TOL))) dut_fast (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .STOP(STOP), .AUDIO_IN(AUDIO_IN),
    .FRAME_VALID(vb), .FRAME_READY(FRAME_READY), .FRAME_PERIOD(pb), .FRAME_DUR(db),
    .OVERFLOW(ovb), .BUSY(bb));

  always #5 CLK = ~CLK;

  typedef struct { int p; int d; } frame_t;
  typedef struct { int ha; int ka; int hb; int kb; int ntone; int p0; int p1; } vec_t;

  frame_t got_a[$], got_b[$], exp_a[$], exp_b[$];
  int edges[$], seg_h[$], seg_k[$];
  int checks = 0, errors = 0, ncyc = 0, t_en = 0, t_end = 0;
  vec_t tbl[5];

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // one clock per iteration; handshakes are recorded while outputs are stable
  task automatic cyc(input int n);
    frame_t f;
    for (int i = 0; i < n; i++) begin
      if (va && FRAME_READY) begin f.p = pa; f.d = da; got_a.push_back(f); end
      if (vb && FRAME_READY) begin f.p = pb; f.d = db; got_b.push_back(f); end
      @(negedge CLK);
      ncyc++;
    end
  endtask

  // reference: frames derived from edge timestamps, then split/drop by tick count
  task automatic build(input int seq, input int which);
    int fp[$], fc[$];
    frame_t q[$];
    frame_t f;
    int t_open, per, d, n, t_sil, diff;
    fp.push_back(0); fc.push_back(edges[0] - t_en);
    t_open = edges[0];
    per = 0;
    for (int i = 1; i < edges.size(); i++) begin
      d = (edges[i] - edges[i-1]) / SD;
      diff = (d > per) ? d - per : per - d;
      if (i == 1) per = d;
      else if (diff > TOL) begin
        fp.push_back(per); fc.push_back(edges[i] - t_open);
        t_open = edges[i];
        per = d;
      end
    end
    t_sil = edges[edges.size()-1] + SIL * SD;
    fp.push_back(per); fc.push_back(t_sil - t_open);
    fp.push_back(0);   fc.push_back(t_end - t_sil);
    for (int i = 0; i < fp.size(); i++) begin
      n = fc[i] / seq;
      while (n >= 1024) begin f.p = fp[i]; f.d = 1023; q.push_back(f); n -= 1024; end
      if (n >= 1 && !(fp[i] == 0 && n == 1)) begin f.p = fp[i]; f.d = n - 1; q.push_back(f); end
    end
    if (which == 0) exp_a = q; else exp_b = q;
  endtask

  task automatic compare(input string nm, input int which);
    frame_t g[$], e[$];
    if (which == 0) begin g = got_a; e = exp_a; end
    else begin g = got_b; e = exp_b; end
    chk(g.size() == e.size(), {nm, " frame count"}, g.size(), e.size());
    for (int i = 0; i < g.size() && i < e.size(); i++) begin
      chk(g[i].p == e[i].p, $sformatf("%s frame %0d period", nm, i), g[i].p, e[i].p);
      chk(g[i].d >= e[i].d - 1 && g[i].d <= e[i].d + 1,
          $sformatf("%s frame %0d dur", nm, i), g[i].d, e[i].d);
    end
  endtask

  task automatic run_tone(input string nm, input int init_sil);
    got_a.delete(); got_b.delete(); edges.delete();
    FRAME_READY = 1'b1;
    ENABLE = 1'b1;
    t_en = ncyc;
    cyc(init_sil);
    for (int j = 0; j < seg_h.size(); j++)
      for (int k = 0; k < seg_k[j]; k++) begin
        AUDIO_IN = ~AUDIO_IN;
        edges.push_back(ncyc);
        cyc(SD * seg_h[j]);
      end
    cyc(SIL * SD + 400);
    ENABLE = 1'b0;
    t_end = ncyc;
    cyc(20);
    build(SQ, 0);
    build(SQF, 1);
    compare({nm, " main"}, 0);
    compare({nm, " fast"}, 1);
    chk(ova == 1'b0, {nm, " overflow"}, ova, 0);
    chk(ba == 1'b0, {nm, " busy after disable"}, ba, 0);
    chk(va == 1'b0, {nm, " valid after drain"}, va, 0);
  endtask

  task automatic toggles(input int h, input int k);
    for (int i = 0; i < k; i++) begin
      AUDIO_IN = ~AUDIO_IN;
      cyc(SD * h);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got 1 expected 0");
    $fatal(1);
  end

  initial begin
    int h, prev, nseg;
    tbl[0] = '{10, 25, 10, 0, 1, 10, 0};
    tbl[1] = '{10, 13, 20, 12, 2, 10, 20};
    tbl[2] = '{10, 13, 11, 10, 1, 10, 0};
    tbl[3] = '{20, 8, 7, 20, 2, 20, 7};
    tbl[4] = '{12, 10, 14, 10, 2, 12, 14};

    #1 RESET = 1'b1;
    #2;
    chk(va == 1'b0, "reset valid", va, 0);
    chk(pa == 16'd0, "reset period", pa, 0);
    chk(da == 10'd0, "reset dur", da, 0);
    chk(ova == 1'b0, "reset overflow", ova, 0);
    chk(ba == 1'b0, "reset busy", ba, 0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    cyc(10);

    for (int r = 0; r < 5; r++) begin
      seg_h.delete(); seg_k.delete();
      seg_h.push_back(tbl[r].ha); seg_k.push_back(tbl[r].ka);
      if (tbl[r].kb > 0) begin seg_h.push_back(tbl[r].hb); seg_k.push_back(tbl[r].kb); end
      run_tone($sformatf("vec%0d", r), 400);
      chk(got_a.size() == tbl[r].ntone + 2, $sformatf("vec%0d tone count", r), got_a.size(), tbl[r].ntone + 2);
      if (got_a.size() >= 2)
        chk(got_a[1].p == tbl[r].p0, $sformatf("vec%0d first period", r), got_a[1].p, tbl[r].p0);
      if (tbl[r].ntone > 1 && got_a.size() >= 3)
        chk(got_a[2].p == tbl[r].p1, $sformatf("vec%0d second period", r), got_a[2].p, tbl[r].p1);
    end

    for (int r = 0; r < 4; r++) begin
      seg_h.delete(); seg_k.delete();
      nseg = $urandom_range(1, 3);
      prev = 0;
      for (int j = 0; j < nseg; j++) begin
        do h = $urandom_range(5, 30); while (prev != 0 && ((h > prev) ? h - prev : prev - h) < 3);
        seg_h.push_back(h);
        seg_k.push_back((300 + 4 * h - 1) / (4 * h) + $urandom_range(0, 3));
        prev = h;
      end
      run_tone($sformatf("rand%0d", r), 4 * $urandom_range(75, 200));
    end

    seg_h.delete(); seg_k.delete();
    seg_h.push_back(5); seg_k.push_back(503);
    run_tone("long", 300);
    if (got_b.size() >= 2) begin
      chk(got_b[1].p == 5, "long split period", got_b[1].p, 5);
      chk(got_b[1].d == 1023, "long split dur", got_b[1].d, 1023);
    end

    got_a.delete();
    FRAME_READY = 1'b1;
    ENABLE = 1'b1;
    cyc(300);
    toggles(10, 12);
    STOP = 1'b1; cyc(1); STOP = 1'b0;
    cyc(20);
    chk(got_a.size() == 3, "stop frame count", got_a.size(), 3);
    if (got_a.size() >= 3) begin
      chk(got_a[1].p == 10, "stop tone period", got_a[1].p, 10);
      chk(got_a[2].p == 0 && got_a[2].d == 0, "stop terminator", got_a[2].p * 1024 + got_a[2].d, 0);
    end
    chk(va == 1'b0, "stop valid after", va, 0);
    chk(ba == 1'b0, "stop busy after", ba, 0);
    ENABLE = 1'b0;
    cyc(10);

    got_a.delete();
    STOP = 1'b1; cyc(1); STOP = 1'b0;
    cyc(10);
    chk(got_a.size() == 0, "stop in idle frames", got_a.size(), 0);
    chk(va == 1'b0, "stop in idle valid", va, 0);

    got_a.delete();
    FRAME_READY = 1'b0;
    ENABLE = 1'b1;
    cyc(300);
    toggles(10, 8);
    toggles(20, 5);
    toggles(5, 17);
    STOP = 1'b1; cyc(1); STOP = 1'b0;
    cyc(50);
    chk(va == 1'b1, "bp valid held", va, 1);
    chk(pa == 16'd0, "bp held period", pa, 0);
    chk(da >= 10'd1 && da <= 10'd3, "bp held dur", da, 2);
    chk(ova == 1'b1, "bp overflow", ova, 1);
    FRAME_READY = 1'b1;
    cyc(10);
    chk(got_a.size() == 2, "bp frame count", got_a.size(), 2);
    if (got_a.size() >= 2)
      chk(got_a[1].p == 0 && got_a[1].d == 0, "bp terminator", got_a[1].p * 1024 + got_a[1].d, 0);
    chk(va == 1'b0, "bp valid after", va, 0);
    ENABLE = 1'b0;
    cyc(10);

    FRAME_READY = 1'b0;
    ENABLE = 1'b1;
    cyc(300);
    AUDIO_IN = ~AUDIO_IN;
    cyc(20);
    chk(ba == 1'b1, "pre-reset busy", ba, 1);
    chk(va == 1'b1, "pre-reset valid", va, 1);
    #2 RESET = 1'b1;
    #1;
    chk(va == 1'b0, "async reset valid", va, 0);
    chk(pa == 16'd0, "async reset period", pa, 0);
    chk(da == 10'd0, "async reset dur", da, 0);
    chk(ova == 1'b0, "async reset overflow", ova, 0);
    chk(ba == 1'b0, "async reset busy", ba, 0);
    @(negedge CLK);
    ncyc++;
    ENABLE = 1'b0;
    FRAME_READY = 1'b1;
    RESET = 1'b0;
    cyc(10);
    seg_h.delete(); seg_k.delete();
    seg_h.push_back(10); seg_k.push_back(15);
    run_tone("after reset", 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
